axi3_sram_slave: RTL and testbench

- AXI3 responder backed by on-chip word-addressed SRAM; the slave end of the CPU core's AXI master port.
- Used as the simulation/FPGA-test memory behind the core top, with no interconnect required.
- Read and write channels are independent. Each channel has one outstanding transaction. Supports FIXED, INCR and WRAP bursts with byte strobes.

---
 rtl/axi3_sram_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi3_sram_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_sram_slave.sv
// AXI3 slave backed by a word-addressed on-chip SRAM.
// Independent read and write channels, one outstanding transaction each.
module axi3_sram_slave #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_AW     = 14
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [31:0]             araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [1:0]              arlock,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [31:0]             awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [1:0]              awlock,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);
    localparam int unsigned Depth = 1 << MEM_AW;

    typedef enum logic [0:0] {RIdle, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    logic [DATA_WIDTH-1:0] mem [Depth];

    r_state_e r_state_q;
    logic [31:0] r_addr_q, r_mask_q;
    logic [7:0] r_len_q, r_cnt_q;
    logic r_fixed_q;

    w_state_e w_state_q;
    logic [ID_WIDTH-1:0] w_id_q;
    logic [31:0] w_addr_q, w_mask_q;
    logic [7:0] w_len_q;
    logic [8:0] w_cnt_q;
    logic w_fixed_q, w_err_q;
    logic w_beat, w_id_ok, w_in_range, w_beat_err, mem_we;

    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot};

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
        return a[MEM_AW+1:2];
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction

    function automatic logic txn_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        return size != 3'b010 || burst == 2'b11 || (burst == 2'b10 && !wrap_len_ok(len));
    endfunction

    // All-ones mask gives a plain +4 step; a legal WRAP confines the step to its window.
    function automatic logic [31:0] step_mask(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b10 && wrap_len_ok(len)) ? {22'd0, len, 2'b11} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic fixed,
                                              input logic [31:0] mask);
        return fixed ? a : ((a & ~mask) | ((a + 32'd4) & mask));
    endfunction

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= RIdle;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            rresp     <= 2'b00;
            r_addr_q  <= '0;
            r_mask_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready   <= 1'b0;
                        rid       <= arid;
                        rresp     <= txn_err(arsize, arburst, arlen) ? 2'b10 : 2'b00;
                        rdata     <= mem[word_idx(araddr)];
                        rvalid    <= 1'b1;
                        rlast     <= (arlen == 8'd0);
                        r_len_q   <= arlen;
                        r_cnt_q   <= 8'd0;
                        r_fixed_q <= (arburst == 2'b00);
                        r_mask_q  <= step_mask(arburst, arlen);
                        r_addr_q  <= next_addr(araddr, arburst == 2'b00,
                                               step_mask(arburst, arlen));
                        r_state_q <= RData;
                    end
                end
                RData: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            arready   <= 1'b1;
                            r_state_q <= RIdle;
                        end else begin
                            rdata    <= mem[word_idx(r_addr_q)];
                            r_addr_q <= next_addr(r_addr_q, r_fixed_q, r_mask_q);
                            r_cnt_q  <= r_cnt_q + 8'd1;
                            rlast    <= (r_cnt_q + 8'd1 == r_len_q);
                        end
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    always_comb begin
        w_beat     = wvalid && wready;
        w_id_ok    = (wid == w_id_q);
        w_in_range = (w_cnt_q <= {1'b0, w_len_q});
        w_beat_err = !w_id_ok || !w_in_range || (wlast && w_cnt_q != {1'b0, w_len_q});
        mem_we     = aresetn && w_beat && w_id_ok && w_in_range;
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= WIdle;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= 2'b00;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_mask_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                        w_id_q    <= awid;
                        w_addr_q  <= awaddr;
                        w_len_q   <= awlen;
                        w_cnt_q   <= 9'd0;
                        w_fixed_q <= (awburst == 2'b00);
                        w_mask_q  <= step_mask(awburst, awlen);
                        w_err_q   <= txn_err(awsize, awburst, awlen);
                        w_state_q <= WData;
                    end
                end
                WData: begin
                    if (w_beat) begin
                        w_addr_q <= next_addr(w_addr_q, w_fixed_q, w_mask_q);
                        // Saturates above any legal len so stray beats stay out of range.
                        if (!w_cnt_q[8]) w_cnt_q <= w_cnt_q + 9'd1;
                        w_err_q <= w_err_q || w_beat_err;
                        if (wlast) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bid       <= w_id_q;
                            bresp     <= (w_err_q || w_beat_err) ? 2'b10 : 2'b00;
                            w_state_q <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready   <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_sram_slave.sv
// Directed bench for axi3_sram_slave: bursts, strobes, backpressure, errors, reset abort.
module tb_axi3_sram_slave;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
    logic [1:0]  arburst = 2'd1, awburst = 2'd1, arlock = '0, awlock = '0, rresp, bresp;
    logic [3:0]  arcache = '0, awcache = '0, wstrb = 4'hF;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;
    logic        arready, awready, wready, rvalid, rlast, bvalid;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [16];

    always #5 aclk = ~aclk;

    axi3_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        while (!awready && n < 20) begin tick(); n++; end
        chk("aw_ready", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
        int n = 0;
        wid = id; wdata = data; wstrb = strb; wlast = last;
        wvalid = 1'b1;
        while (!wready && n < 20) begin tick(); n++; end
        chk("w_ready", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_wait(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, "_bid"}, 32'(bid), 32'(id));
        chk({tag, "_bresp"}, 32'(bresp), 32'(resp));
        tick();
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        chk("ar_ready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("r_latency", 32'(rvalid), 32'd1);
    endtask

    task automatic read_beats(input string tag, input int nb, input logic [3:0] id,
                              input logic [1:0] resp);
        rready = 1'b1;
        for (int i = 0; i < nb; i++) begin
            int n = 0;
            while (!rvalid && n < 20) begin tick(); n++; end
            chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            chk({tag, "_rdata"}, rdata, exp_q[i]);
            chk({tag, "_rlast"}, 32'(rlast), 32'(i == nb - 1));
            chk({tag, "_rid"}, 32'(rid), 32'(id));
            chk({tag, "_rresp"}, 32'(rresp), 32'(resp));
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        do_aw(id, addr, len, 3'd2, burst);
        for (int i = 0; i <= int'(len); i++) do_w(id, exp_q[i], 4'hF, i == int'(len));
        b_wait("wr", id, 2'b00);
    endtask

    initial begin
        int beat;
        int cyc;
        logic hs;

        // Reset state
        repeat (3) tick();
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        tick();
        chk("rel_arready", 32'(arready), 32'd1);
        chk("rel_awready", 32'(awready), 32'd1);

        // 1: INCR write then read-back
        for (int i = 0; i < 4; i++) exp_q[i] = 32'hA0 + 32'(i);
        do_aw(4'd3, 32'h100, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) do_w(4'd3, exp_q[i], 4'hF, i == 3);
        b_wait("t1", 4'd3, 2'b00);
        do_ar(4'd4, 32'h100, 8'd3, 3'd2, 2'b01);
        read_beats("t1", 4, 4'd4, 2'b00);

        // 2: WRAP read starting mid-window
        for (int i = 0; i < 4; i++) exp_q[i] = 32'(i + 1);
        wr_burst(4'd1, 32'h40, 8'd3, 2'b01);
        exp_q[0] = 32'd3; exp_q[1] = 32'd4; exp_q[2] = 32'd1; exp_q[3] = 32'd2;
        do_ar(4'd2, 32'h48, 8'd3, 3'd2, 2'b10);
        read_beats("t2", 4, 4'd2, 2'b00);

        // 3: byte strobes, then FIXED burst
        exp_q[0] = 32'h1122_3344;
        wr_burst(4'd1, 32'h200, 8'd0, 2'b01);
        do_aw(4'd1, 32'h200, 8'd0, 3'd2, 2'b01);
        do_w(4'd1, 32'hAABB_CCDD, 4'b0101, 1'b1);
        b_wait("t3s", 4'd1, 2'b00);
        exp_q[0] = 32'h11BB_33DD;
        do_ar(4'd1, 32'h200, 8'd0, 3'd2, 2'b01);
        read_beats("t3s", 1, 4'd1, 2'b00);
        exp_q[0] = 32'd5; exp_q[1] = 32'd6; exp_q[2] = 32'd7;
        wr_burst(4'd2, 32'h204, 8'd2, 2'b00);
        exp_q[0] = 32'd7;
        do_ar(4'd2, 32'h204, 8'd0, 3'd2, 2'b01);
        read_beats("t3f", 1, 4'd2, 2'b00);

        // 4: read backpressure with rready pattern 1,0,0
        for (int i = 0; i < 8; i++) exp_q[i] = 32'hC0 + 32'(i);
        wr_burst(4'd6, 32'h300, 8'd7, 2'b01);
        do_ar(4'd7, 32'h300, 8'd7, 3'd2, 2'b01);
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 60) begin
            if (rvalid) begin
                chk("t4_rdata", rdata, 32'hC0 + 32'(beat));
                chk("t4_rlast", 32'(rlast), 32'(beat == 7));
                chk("t4_rid", 32'(rid), 32'd7);
            end
            rready = (cyc % 3 == 0);
            hs = rvalid && rready;
            tick();
            if (hs) beat++;
            cyc++;
        end
        rready = 1'b0;
        chk("t4_beats", 32'(beat), 32'd8);
        chk("t4_idle", 32'(rvalid), 32'd0);

        // 4b: write response backpressure
        do_aw(4'd5, 32'h400, 8'd0, 3'd2, 2'b01);
        do_w(4'd5, 32'h55, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t4b_bvalid", 32'(bvalid), 32'd1);
            chk("t4b_bid", 32'(bid), 32'd5);
            chk("t4b_awready", 32'(awready), 32'd0);
            tick();
        end
        b_wait("t4b", 4'd5, 2'b00);

        // 5: error responses
        exp_q[0] = 32'hA0; exp_q[1] = 32'hA1;
        do_ar(4'd2, 32'h100, 8'd1, 3'd1, 2'b01);
        read_beats("t5_size", 2, 4'd2, 2'b10);
        do_aw(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
        do_w(4'd4, 32'hDEAD_BEEF, 4'hF, 1'b1);
        b_wait("t5_wid", 4'd3, 2'b10);
        exp_q[0] = 32'hA0;
        do_ar(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
        read_beats("t5_keep", 1, 4'd3, 2'b00);
        do_aw(4'd3, 32'h500, 8'd3, 3'd2, 2'b01);
        do_w(4'd3, 32'd1, 4'hF, 1'b0);
        do_w(4'd3, 32'd2, 4'hF, 1'b1);
        b_wait("t5_early", 4'd3, 2'b10);
        exp_q[0] = 32'h77;
        wr_burst(4'd8, 32'h500, 8'd0, 2'b01);
        do_ar(4'd8, 32'h500, 8'd0, 3'd2, 2'b01);
        read_beats("t5_after", 1, 4'd8, 2'b00);

        // 6: reset during beat 2 of a len=7 read
        do_ar(4'd5, 32'h300, 8'd7, 3'd2, 2'b01);
        rready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("t6_pre", rdata, 32'hC0 + 32'(i));
            tick();
        end
        chk("t6_beat2", rdata, 32'hC2);
        aresetn = 1'b0;
        rready = 1'b0;
        tick();
        chk("t6_rvalid", 32'(rvalid), 32'd0);
        chk("t6_arready", 32'(arready), 32'd0);
        chk("t6_rlast", 32'(rlast), 32'd0);
        aresetn = 1'b1;
        tick();
        chk("t6_rel_arready", 32'(arready), 32'd1);
        exp_q[0] = 32'hC2;
        do_ar(4'd9, 32'h308, 8'd0, 3'd2, 2'b01);
        read_beats("t6_new", 1, 4'd9, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
